// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WAIT_W     = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the controller's performance counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch squashes, memory-wait
// freeze with a timeout watchdog, and saturating performance counters.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  ex_mem_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_flush,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic                  mem_timeout
);

    ctrl_state_t       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic load_use;
    logic mem_stall;
    logic freeze;
    logic in_error;

    assign load_use  = ex_mem_read && (ex_rd != REG_ADDR_W'(0)) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));
    assign mem_stall = mem_req && !mem_ready;
    assign in_error  = (state_q == ERROR);
    assign freeze    = mem_stall || in_error;

    // Pipeline enables/flushes in priority order: freeze, branch, load-use.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // Watchdog FSM; wait_cnt counts completed frozen cycles in MEM_WAIT.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d       = ERROR;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   ((mem_stall || load_use) && !in_error),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_taken && !freeze),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized scoreboard bench for hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;

    localparam int unsigned TB_TO  = 4;
    localparam int unsigned TB_W   = 4;
    localparam int          CNTMAX = (1 << TB_W) - 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
    logic       branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic       if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout;
    logic [TB_W-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(TB_TO), .CNT_W(TB_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush),
        .stall_cycles(stall_cycles), .flush_count(flush_count),
        .mem_timeout(mem_timeout)
    );

    typedef struct {
        logic [6:0] ctl;   // pc, if_id, id_ex, ex_mem writes; if_id, id_ex, mem_wb flushes
        int         now_stall, now_flush, now_to;
        int         aft_stall, aft_flush, aft_to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: consecutive-stall count, error flag, integer counters.
    int m_consec = 0, m_err = 0, m_stall = 0, m_flush = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input int rs1, input int rs2, input logic u1,
                         input logic u2, input logic mr, input int rd, input logic br,
                         input logic req, input logic rdy);
        exp_t e;
        int   lu, ms, frz;
        @(negedge clk);
        reset = rst; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
        ex_mem_read = mr; ex_rd = 5'(rd); branch_taken = br; mem_req = req; mem_ready = rdy;
        if (rst) begin
            m_consec = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end
        lu  = (mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd))) ? 1 : 0;
        ms  = (req && !rdy) ? 1 : 0;
        frz = (ms != 0 || m_err != 0) ? 1 : 0;
        if (frz != 0)     e.ctl = 7'b0000_001;
        else if (br)      e.ctl = 7'b1111_110;
        else if (lu != 0) e.ctl = 7'b0011_010;
        else              e.ctl = 7'b1111_000;
        e.now_stall = m_stall; e.now_flush = m_flush; e.now_to = m_err;
        if (!rst) begin
            if (m_err == 0 && (ms != 0 || lu != 0) && m_stall < CNTMAX) m_stall++;
            if (br && frz == 0 && m_flush < CNTMAX) m_flush++;
            if (m_err == 0) begin
                m_consec = (ms != 0) ? m_consec + 1 : 0;
                if (m_consec >= int'(TB_TO)) m_err = 1;
            end
        end
        e.aft_stall = m_stall; e.aft_flush = m_flush; e.aft_to = m_err;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic rst);
        drive(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pop one expectation per cycle that has one queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("controls", int'({pc_write, if_id_write, id_ex_write, ex_mem_write,
                                        if_id_flush, id_ex_flush, mem_wb_flush}), int'(e.ctl));
                check("stall_now", int'(stall_cycles), e.now_stall);
                check("flush_now", int'(flush_count), e.now_flush);
                check("timeout_now", int'(mem_timeout), e.now_to);
                @(posedge clk);
                #1;
                check("stall_after", int'(stall_cycles), e.aft_stall);
                check("flush_after", int'(flush_count), e.aft_flush);
                check("timeout_after", int'(mem_timeout), e.aft_to);
            end
        end
    end

    initial begin
        idle(1); idle(1); idle(0);
        // load-use on rs2, then same with x0 destination
        drive(0, 1, 5, 0, 1, 1, 5, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        // branch wins over load-use
        drive(0, 1, 5, 0, 1, 1, 5, 1, 0, 0);
        idle(1); idle(0);
        // three-cycle memory wait, then completion
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(0);
        // timeout after TB_TO stalls; stays frozen, branch ignored
        repeat (TB_TO) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        drive(0, 1, 5, 0, 1, 1, 5, 0, 0, 0);
        idle(1); idle(0);
        // saturation
        repeat (20) drive(0, 7, 2, 1, 0, 1, 7, 0, 0, 0);
        idle(1); idle(0);
        // reset mid-wait
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1); idle(0);
        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 59) == 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0));
        end
        idle(0);
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
